// File: rtl/vme_cmd_player_if.sv
// VME request/completion bundle between the command player and vme_master.
//   master modport: player side (drives request, address, write data; sees completion, read data)
//   slave modport : vme_master side
//   vme_cmd      1-cycle request pulse
//   vme_wr/rd    cycle type, valid with vme_cmd, held until the next request
//   vme_addr     VME address [23:1], held from vme_cmd until completion
//   vme_wr_data  write data, held from vme_cmd until completion
//   vme_cmd_rd   1-cycle completion pulse
//   vme_rd_data  read data, valid while vme_cmd_rd is high
interface vme_cmd_player_if;
    logic        vme_cmd;
    logic        vme_wr;
    logic        vme_rd;
    logic [22:0] vme_addr;
    logic [15:0] vme_wr_data;
    logic        vme_cmd_rd;
    logic [15:0] vme_rd_data;

    modport master (
        output vme_cmd, vme_wr, vme_rd, vme_addr, vme_wr_data,
        input  vme_cmd_rd, vme_rd_data
    );

    modport slave (
        input  vme_cmd, vme_wr, vme_rd, vme_addr, vme_wr_data,
        output vme_cmd_rd, vme_rd_data
    );
endinterface

// File: rtl/vme_cmd_player.sv
// Command player feeding vme_master. Walks the command/data memory pair from entry 0,
// issues one VME single-word write or read per entry, waits for completion (or timeout),
// checks read data against an expected value under a mask and logs every read (and every
// timed-out cycle) into the result memory.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   start, stop               1-cycle pulses: begin playback / abort after in-flight cycle
//   mem_addr, mem_rden        command/data memory read port (data valid 1 cycle later)
//   cmd_mem_out, dat_mem_out  command word {op[31:30], cmp_en[24], addr[22:0]}, data word {mask, data}
//   vme                       request/completion bundle to vme_master (master modport)
//   res_mem_wren/addr/in      result memory write port: {timeout, mismatch, 14'b0, rd_data}
//   busy, done, err_count     status: playback active, end-of-playback pulse, saturating error count
module vme_cmd_player #(
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rden,
    input  logic [31:0]       cmd_mem_out,
    input  logic [31:0]       dat_mem_out,
    vme_cmd_player_if.master  vme,
    output logic              res_mem_wren,
    output logic [ADDR_W-1:0] res_mem_addr,
    output logic [31:0]       res_mem_in,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_count
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT_MEM, S_DECODE, S_ISSUE,
        S_WAIT_ACK, S_STORE, S_NEXT, S_FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_WR  = 2'b01,
        OP_RD  = 2'b10,
        OP_END = 2'b11
    } op_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] ptr;
    op_t               op_q;
    logic              cmp_en_q;
    logic [22:0]       addr_q;
    logic [31:0]       dat_q;
    logic              stop_q;
    logic [TW-1:0]     tcnt;
    logic [15:0]       rd_data_q;
    logic              timeout_q;
    logic              vme_wr_q, vme_rd_q;
    logic [22:0]       vme_addr_q;
    logic [15:0]       vme_wr_data_q;
    logic [15:0]       err_q;
    logic              vme_cmd_c;
    logic              mismatch;
    logic              stop_seen;
    logic              timed_out;

    // Reserved command-word bits carry nothing.
    logic unused_cmd_bits;
    assign unused_cmd_bits = &{1'b0, cmd_mem_out[29:25], cmd_mem_out[23]};

    assign stop_seen = stop_q | stop;
    assign timed_out = (state == S_WAIT_ACK) && !vme.vme_cmd_rd && (tcnt == TMAX);
    // Data word holds the expected value only for reads; write entries never flag a mismatch.
    assign mismatch  = (op_q == OP_RD) && cmp_en_q &&
                       (|((rd_data_q ^ dat_q[15:0]) & dat_q[31:16]));

    // Next-state and strobe decode
    always_comb begin
        state_d      = state;
        mem_rden     = 1'b0;
        vme_cmd_c    = 1'b0;
        res_mem_wren = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH: begin
                mem_rden = 1'b1;
                state_d  = S_WAIT_MEM;
            end
            S_WAIT_MEM: state_d = S_DECODE;
            S_DECODE: begin
                case (op_q)
                    OP_NOP:  state_d = S_NEXT;
                    OP_END:  state_d = S_FINISH;
                    default: state_d = S_ISSUE;
                endcase
            end
            S_ISSUE: begin
                vme_cmd_c = 1'b1;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (vme.vme_cmd_rd)
                    state_d = (op_q == OP_RD) ? S_STORE : S_NEXT;
                else if (tcnt == TMAX)
                    state_d = S_STORE;
            end
            S_STORE: begin
                res_mem_wren = 1'b1;
                state_d      = S_NEXT;
            end
            S_NEXT: begin
                if (stop_seen || (ptr == '1))
                    state_d = S_FINISH;
                else
                    state_d = S_FETCH;
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr           <= '0;
            op_q          <= OP_NOP;
            cmp_en_q      <= 1'b0;
            addr_q        <= '0;
            dat_q         <= '0;
            stop_q        <= 1'b0;
            tcnt          <= '0;
            rd_data_q     <= '0;
            timeout_q     <= 1'b0;
            vme_wr_q      <= 1'b0;
            vme_rd_q      <= 1'b0;
            vme_addr_q    <= '0;
            vme_wr_data_q <= '0;
            err_q         <= '0;
        end else begin
            if (state == S_NEXT && state_d == S_FETCH)
                ptr <= ptr + 1'b1;
            else if (state == S_FINISH)
                ptr <= '0;

            if (state == S_WAIT_MEM) begin
                op_q     <= op_t'(cmd_mem_out[31:30]);
                cmp_en_q <= cmd_mem_out[24];
                addr_q   <= cmd_mem_out[22:0];
                dat_q    <= dat_mem_out;
            end

            // Sticky abort request; a stop arriving with the accepted start still counts.
            if (state == S_FINISH)
                stop_q <= 1'b0;
            else if (stop && (state != S_IDLE || start))
                stop_q <= 1'b1;

            // Counts cycles since the request pulse: 0 during ISSUE.
            if (state == S_DECODE)
                tcnt <= '0;
            else if (state == S_ISSUE || state == S_WAIT_ACK)
                tcnt <= tcnt + 1'b1;

            if (state == S_WAIT_ACK) begin
                if (vme.vme_cmd_rd) begin
                    rd_data_q <= vme.vme_rd_data;
                    timeout_q <= 1'b0;
                end else if (timed_out) begin
                    rd_data_q <= '0;
                    timeout_q <= 1'b1;
                end
            end

            if (state == S_DECODE && (op_q == OP_WR || op_q == OP_RD)) begin
                vme_wr_q      <= (op_q == OP_WR);
                vme_rd_q      <= (op_q == OP_RD);
                vme_addr_q    <= addr_q;
                vme_wr_data_q <= dat_q[15:0];
            end else if (state == S_FINISH) begin
                vme_wr_q <= 1'b0;
                vme_rd_q <= 1'b0;
            end

            if (state == S_IDLE && start)
                err_q <= '0;
            else if (state == S_STORE && (mismatch || timeout_q) && err_q != 16'hFFFF)
                err_q <= err_q + 16'd1;
        end
    end

    assign mem_addr        = ptr;
    assign res_mem_addr    = ptr;
    assign res_mem_in      = {timeout_q, mismatch, 14'b0, rd_data_q};
    assign busy            = (state != S_IDLE) && (state != S_FINISH);
    assign err_count       = err_q;
    assign vme.vme_cmd     = vme_cmd_c;
    assign vme.vme_wr      = vme_wr_q;
    assign vme.vme_rd      = vme_rd_q;
    assign vme.vme_addr    = vme_addr_q;
    assign vme.vme_wr_data = vme_wr_data_q;

endmodule

// File: tb/tb_vme_cmd_player.sv
// Scoreboard bench for vme_cmd_player: directed command tables, a behavioural command/data
// memory and VME master, expected requests/results queued at stimulus time and popped by a
// monitor whenever the player presents a request or a result write.
module tb_vme_cmd_player;
    localparam int AW = 6;
    localparam int TO = 40;
    localparam int N  = 1 << AW;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] WR  = 2'b01;
    localparam logic [1:0] RD  = 2'b10;
    localparam logic [1:0] EN  = 2'b11;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rden;
    logic [31:0]   cmd_mem_out = '0;
    logic [31:0]   dat_mem_out = '0;
    logic          res_mem_wren;
    logic [AW-1:0] res_mem_addr;
    logic [31:0]   res_mem_in;
    logic          busy;
    logic          done;
    logic [15:0]   err_count;

    vme_cmd_player_if vme();

    vme_cmd_player #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .stop         (stop),
        .mem_addr     (mem_addr),
        .mem_rden     (mem_rden),
        .cmd_mem_out  (cmd_mem_out),
        .dat_mem_out  (dat_mem_out),
        .vme          (vme),
        .res_mem_wren (res_mem_wren),
        .res_mem_addr (res_mem_addr),
        .res_mem_in   (res_mem_in),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic wr; logic [22:0] addr; logic [15:0] data; } vme_exp_t;
    typedef struct { int delay; logic [15:0] data; } resp_t;
    typedef struct { logic [AW-1:0] addr; logic [31:0] data; } res_exp_t;

    vme_exp_t vme_q[$];
    resp_t    resp_q[$];
    res_exp_t res_q[$];

    logic [31:0] cmd_mem [N];
    logic [31:0] dat_mem [N];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int first_cmd_cyc = 0;
    int cmd_count = 0;
    int rden_count = 0;
    logic [AW-1:0] last_rd_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_rden) begin
            cmd_mem_out <= cmd_mem[mem_addr];
            dat_mem_out <= dat_mem[mem_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_cmd(input logic [1:0] op, input logic cmp, input logic [22:0] a);
        return {op, 5'b0, cmp, 1'b0, a};
    endfunction

    task automatic put(input int idx, input logic [1:0] op, input logic cmp,
                       input logic [22:0] a, input logic [15:0] mask, input logic [15:0] d);
        cmd_mem[idx] = mk_cmd(op, cmp, a);
        dat_mem[idx] = {mask, d};
    endtask

    task automatic exp_vme(input logic wr, input logic [22:0] a, input logic [15:0] d,
                           input int delay, input logic [15:0] rdata);
        vme_exp_t e;
        resp_t r;
        e.wr = wr; e.addr = a; e.data = d;
        r.delay = delay; r.data = rdata;
        vme_q.push_back(e);
        resp_q.push_back(r);
    endtask

    task automatic exp_res(input int idx, input logic [31:0] d);
        res_exp_t e;
        e.addr = AW'(idx); e.data = d;
        res_q.push_back(e);
    endtask

    // Behavioural vme_master: completion pulse `delay` cycles after the request, never if delay < 0.
    initial begin
        resp_t r;
        vme.vme_cmd_rd  = 1'b0;
        vme.vme_rd_data = '0;
        forever begin
            @(negedge clk);
            vme.vme_cmd_rd = 1'b0;
            if (rstn && vme.vme_cmd && resp_q.size() > 0) begin
                r = resp_q.pop_front();
                if (r.delay > 0) begin
                    repeat (r.delay - 1) @(negedge clk);
                    vme.vme_cmd_rd  = 1'b1;
                    vme.vme_rd_data = r.data;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        vme_exp_t ev;
        res_exp_t er;
        if (rstn) begin
            if (vme.vme_cmd) begin
                if (cmd_count == 0) first_cmd_cyc = cyc;
                cmd_count++;
                check("vme_cmd_expected", 32'(vme_q.size() > 0), 32'd1);
                if (vme_q.size() > 0) begin
                    ev = vme_q.pop_front();
                    check("vme_wr", 32'(vme.vme_wr), 32'(ev.wr));
                    check("vme_rd", 32'(vme.vme_rd), 32'(!ev.wr));
                    check("vme_addr", 32'(vme.vme_addr), 32'(ev.addr));
                    if (ev.wr) check("vme_wr_data", 32'(vme.vme_wr_data), 32'(ev.data));
                end
            end
            if (res_mem_wren) begin
                check("res_wr_expected", 32'(res_q.size() > 0), 32'd1);
                if (res_q.size() > 0) begin
                    er = res_q.pop_front();
                    check("res_mem_addr", 32'(res_mem_addr), 32'(er.addr));
                    check("res_mem_in", res_mem_in, er.data);
                end
            end
            if (mem_rden) begin
                rden_count++;
                last_rd_addr = mem_addr;
            end
        end
    end

    // Starts playback (optionally with stop in the same cycle or a stop after the
    // n-th request), waits for done within budget and checks the queues drained.
    task automatic run(input int budget, input logic stop_with_start, input int stop_after);
        int n;
        int wait_c;
        logic stopped;
        n = 0; wait_c = 0; stopped = 1'b0;
        @(negedge clk);
        cmd_count = 0;
        rden_count = 0;
        start = 1'b1;
        stop = stop_with_start;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            stop = 1'b0;
            if (stop_after > 0 && !stopped && cmd_count >= stop_after) begin
                if (wait_c == 2) begin
                    stop = 1'b1;
                    stopped = 1'b1;
                end else begin
                    wait_c++;
                end
            end
        end
        check("done_seen", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        stop = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
        check("vme_q_drained", 32'(vme_q.size()), 32'd0);
        check("res_q_drained", 32'(res_q.size()), 32'd0);
        resp_q.delete();
        vme_q.delete();
        res_q.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) put(i, EN, 1'b0, '0, '0, '0);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_strobes", 32'({mem_rden, vme.vme_cmd, vme.vme_wr, vme.vme_rd,
                                  res_mem_wren, busy, done}), 32'd0);
        check("rst_vme_addr", 32'(vme.vme_addr), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_res_mem_in", res_mem_in, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: single write then END, ack after 5 cycles
        put(0, WR, 1'b0, 23'h00070, 16'h0000, 16'h1234);
        put(1, EN, 1'b0, '0, '0, '0);
        exp_vme(1'b1, 23'h00070, 16'h1234, 5, 16'h0000);
        run(200, 1'b0, 0);
        check("t1_latency", 32'(first_cmd_cyc - start_cyc), 32'd4);
        check("t1_cmds", 32'(cmd_count), 32'd1);
        check("t1_err", 32'(err_count), 32'd0);
        check("t1_wr_idle", 32'(vme.vme_wr), 32'd0);
        check("t1_addr_hold", 32'(vme.vme_addr), 32'h00070);

        // stop while idle must be ignored
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;

        // 2: compared reads, match then single-bit mismatch
        put(0, RD, 1'b1, 23'h00100, 16'hFFFF, 16'hBEEF);
        put(1, RD, 1'b1, 23'h00101, 16'hFFFF, 16'hBEEF);
        put(2, EN, 1'b0, '0, '0, '0);
        exp_vme(1'b0, 23'h00100, 16'h0000, 3, 16'hBEEF);
        exp_vme(1'b0, 23'h00101, 16'h0000, 4, 16'hBEEE);
        exp_res(0, 32'h0000BEEF);
        exp_res(1, 32'h4000BEEE);
        run(200, 1'b0, 0);
        check("t2_cmds", 32'(cmd_count), 32'd2);
        check("t2_err", 32'(err_count), 32'd1);

        // 3: masked compare ignores upper byte; start clears err_count
        put(0, RD, 1'b1, 23'h00200, 16'h00FF, 16'h1234);
        put(1, EN, 1'b0, '0, '0, '0);
        exp_vme(1'b0, 23'h00200, 16'h0000, 2, 16'hAB34);
        exp_res(0, 32'h0000AB34);
        run(200, 1'b0, 0);
        check("t3_err", 32'(err_count), 32'd0);

        // 4: master never acks a read nor a write; both logged as timeouts
        put(0, RD, 1'b0, 23'h00055, 16'h0000, 16'h0000);
        put(1, WR, 1'b0, 23'h00056, 16'h0000, 16'h9999);
        put(2, NOP, 1'b0, '0, '0, '0);
        put(3, EN, 1'b0, '0, '0, '0);
        exp_vme(1'b0, 23'h00055, 16'h0000, -1, 16'h0000);
        exp_vme(1'b1, 23'h00056, 16'h9999, -1, 16'h0000);
        exp_res(0, 32'h80000000);
        exp_res(1, 32'h80000000);
        run(1000, 1'b0, 0);
        check("t4_cmds", 32'(cmd_count), 32'd2);
        check("t4_err", 32'(err_count), 32'd2);

        // 5: stop during WAIT_ACK of entry 2 of 5
        put(0, WR, 1'b0, 23'h00300, 16'h0000, 16'h0001);
        put(1, WR, 1'b0, 23'h00301, 16'h0000, 16'h0002);
        put(2, RD, 1'b1, 23'h00302, 16'h0000, 16'h0000);
        put(3, WR, 1'b0, 23'h00303, 16'h0000, 16'h0004);
        put(4, WR, 1'b0, 23'h00304, 16'h0000, 16'h0005);
        put(5, EN, 1'b0, '0, '0, '0);
        exp_vme(1'b1, 23'h00300, 16'h0001, 3, 16'h0000);
        exp_vme(1'b1, 23'h00301, 16'h0002, 3, 16'h0000);
        exp_vme(1'b0, 23'h00302, 16'h0000, 10, 16'h5A5A);
        exp_res(2, 32'h00005A5A);
        run(300, 1'b0, 3);
        check("t5_cmds", 32'(cmd_count), 32'd3);
        check("t5_err", 32'(err_count), 32'd0);

        // 7: start and stop together: only entry 0 played
        put(0, WR, 1'b0, 23'h00400, 16'h0000, 16'hCAFE);
        put(1, WR, 1'b0, 23'h00401, 16'h0000, 16'hF00D);
        put(2, EN, 1'b0, '0, '0, '0);
        exp_vme(1'b1, 23'h00400, 16'hCAFE, 2, 16'h0000);
        run(200, 1'b1, 0);
        check("t7_cmds", 32'(cmd_count), 32'd1);

        // 6: all NOPs, walks every entry, stops at the last without wrapping
        for (int i = 0; i < N; i++) put(i, NOP, 1'b0, '0, '0, '0);
        run(2000, 1'b0, 0);
        check("t6_cmds", 32'(cmd_count), 32'd0);
        check("t6_fetches", 32'(rden_count), 32'(N));
        check("t6_last_addr", 32'(last_rd_addr), 32'(N - 1));
        check("t6_ptr_cleared", 32'(mem_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
